// File: rtl/spi_slave_param_if.sv
// Pin and word-handshake bundle between an SPI slave and its surroundings.
interface spi_slave_param_if #(
    parameter int unsigned DATA_W = 8
);
    logic              sck;
    logic              ssel_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic              frame_active;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              overrun;
    logic              underrun;
    logic              err_clr;

    modport slave (
        input  sck, ssel_n, mosi, rx_ready, tx_data, tx_valid, err_clr,
        output miso, miso_oe, frame_active, rx_data, rx_valid, tx_ready, overrun, underrun
    );

    modport master (
        output sck, ssel_n, mosi, rx_ready, tx_data, tx_valid, err_clr,
        input  miso, miso_oe, frame_active, rx_data, rx_valid, tx_ready, overrun, underrun
    );
endinterface

// File: rtl/spi_slave_param.sv
// Parameterised oversampling SPI slave (any CPOL/CPHA, MSB/LSB first, valid/ready words).
// Sticky overrun/underrun flags are built only when SPI_SLAVE_ERR_FLAGS_EN is defined.
module spi_slave_param #(
    parameter int unsigned DATA_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              rst,
    spi_slave_param_if.slave bus
);
    localparam int unsigned      CNT_W       = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(DATA_W - 1);
    localparam bit               SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, ssel_sync_q, mosi_sync_q;
    logic                   sck_prev_q, ssel_prev_q;

    // Pin synchronisers; idle levels on reset so no phantom edge appears afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= {SYNC_STAGES{CPOL}};
            ssel_sync_q <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= CPOL;
            ssel_prev_q <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
            ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], bus.ssel_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            ssel_prev_q <= ssel_sync_q[SYNC_STAGES-1];
        end
    end

    logic sck_s, ssel_s, mosi_s;
    logic sample_c, shift_edge_c, frame_start_c, frame_end_c;
    assign sck_s         = sck_sync_q[SYNC_STAGES-1];
    assign ssel_s        = ssel_sync_q[SYNC_STAGES-1];
    assign mosi_s        = mosi_sync_q[SYNC_STAGES-1];
    assign sample_c      = SAMPLE_RISE ? (sck_s & ~sck_prev_q) : (~sck_s & sck_prev_q);
    assign shift_edge_c  = SAMPLE_RISE ? (~sck_s & sck_prev_q) : (sck_s & ~sck_prev_q);
    assign frame_start_c = ssel_prev_q & ~ssel_s;
    assign frame_end_c   = ~ssel_prev_q & ssel_s;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
    logic              hold_empty_q, hold_empty_d;
    logic              rx_valid_q, rx_valid_d;
    logic              done_q, done_d;
    logic              skip_q, skip_d;
    logic              reload_c, shift_c, ovr_set_c, und_set_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            rx_sr_q      <= '0;
            tx_sr_q      <= '0;
            hold_q       <= '0;
            hold_empty_q <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            skip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_sr_q      <= rx_sr_d;
            tx_sr_q      <= tx_sr_d;
            hold_q       <= hold_d;
            hold_empty_q <= hold_empty_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            done_q       <= done_d;
            skip_q       <= skip_d;
        end
    end

    // skip_q: the next shift edge reloads (CPHA=0) or is ignored (CPHA=1) instead of shifting
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_sr_d      = rx_sr_q;
        tx_sr_d      = tx_sr_q;
        hold_d       = hold_q;
        hold_empty_d = hold_empty_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        done_d       = 1'b0;
        skip_d       = skip_q;
        reload_c     = 1'b0;
        shift_c      = 1'b0;
        ovr_set_c    = 1'b0;
        und_set_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start_c) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    reload_c  = 1'b1;
                    skip_d    = CPHA;
                end
            end
            ST_ACTIVE: begin
                if (frame_end_c) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    tx_sr_d   = '0;
                    skip_d    = 1'b0;
                end else begin
                    if (sample_c) begin
                        rx_sr_d = MSB_FIRST ? {rx_sr_q[DATA_W-2:0], mosi_s}
                                            : {mosi_s, rx_sr_q[DATA_W-1:1]};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            done_d    = 1'b1;
                            skip_d    = 1'b1;
                            reload_c  = CPHA;
                        end else begin
                            bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                        end
                    end
                    if (shift_edge_c) begin
                        if (skip_q) begin
                            skip_d   = 1'b0;
                            reload_c = ~CPHA;
                        end else begin
                            shift_c = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (shift_c) begin
            tx_sr_d = MSB_FIRST ? {tx_sr_q[DATA_W-2:0], 1'b0} : {1'b0, tx_sr_q[DATA_W-1:1]};
        end
        // A reload sees the holding register as it was before any same-cycle accept
        if (reload_c) begin
            if (!hold_empty_q) begin
                tx_sr_d      = hold_q;
                hold_empty_d = 1'b1;
            end else begin
                tx_sr_d   = '0;
                und_set_c = 1'b1;
            end
        end
        if (bus.tx_valid && hold_empty_q) begin
            hold_d       = bus.tx_data;
            hold_empty_d = 1'b0;
        end

        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (done_q) begin
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            ovr_set_c  = rx_valid_q & ~bus.rx_ready;
        end
    end

    assign bus.frame_active = (state_q == ST_ACTIVE);
    assign bus.miso_oe      = (state_q == ST_ACTIVE);
    assign bus.miso         = (state_q == ST_ACTIVE) &
                              (MSB_FIRST ? tx_sr_q[DATA_W-1] : tx_sr_q[0]);
    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.tx_ready     = hold_empty_q;

`ifdef SPI_SLAVE_ERR_FLAGS_EN
    logic ovr_q, ovr_d, und_q, und_d;
    assign ovr_d = ovr_set_c | (ovr_q & ~bus.err_clr);
    assign und_d = und_set_c | (und_q & ~bus.err_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
            und_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
            und_q <= und_d;
        end
    end

    assign bus.overrun  = ovr_q;
    assign bus.underrun = und_q;
`else
    logic unused_err_c;
    assign unused_err_c = bus.err_clr ^ ovr_set_c ^ und_set_c;
    assign bus.overrun  = 1'b0;
    assign bus.underrun = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: mode 0 / 8-bit MSB-first and mode 3 / 16-bit LSB-first instances.
module tb_spi_slave_param;
    localparam int HALF = 8;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    localparam logic [31:0] FLAG_EXP = 32'd1;
`else
    localparam logic [31:0] FLAG_EXP = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_param_if #(.DATA_W(8))  b0 ();
    spi_slave_param_if #(.DATA_W(16)) b3 ();

    spi_slave_param #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    spi_slave_param #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(2))
        u3 (.clk(clk), .rst(rst), .bus(b3));

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  q0[$];
    logic [15:0] q3[$];

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted word is matched against the oldest expectation
    always @(negedge clk) begin
        logic [7:0]  e0;
        logic [15:0] e3;
        if (!rst && b0.rx_valid && b0.rx_ready) begin
            if (q0.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rx0_unexpected: got %h expected none", b0.rx_data);
            end else begin
                e0 = q0.pop_front();
                chk("rx0_word", 32'(b0.rx_data), 32'(e0));
            end
        end
        if (!rst && b3.rx_valid && b3.rx_ready) begin
            if (q3.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rx3_unexpected: got %h expected none", b3.rx_data);
            end else begin
                e3 = q3.pop_front();
                chk("rx3_word", 32'(b3.rx_data), 32'(e3));
            end
        end
    end

    task automatic drain(input int sel);
        int n = 0;
        while (((sel == 0) ? q0.size() : q3.size()) != 0 && n < 100) begin
            tick(1);
            n++;
        end
        chk("rx_drain_pending", 32'((sel == 0) ? q0.size() : q3.size()), 32'd0);
    endtask

    task automatic load_tx0(input logic [7:0] w);
        int n = 0;
        while (!b0.tx_ready && n < 50) begin tick(1); n++; end
        chk("tx0_ready_wait", 32'(b0.tx_ready), 32'd1);
        b0.tx_data  = w;
        b0.tx_valid = 1'b1;
        tick(1);
        b0.tx_valid = 1'b0;
        chk("tx0_ready_drop", 32'(b0.tx_ready), 32'd0);
    endtask

    task automatic load_tx3(input logic [15:0] w);
        int n = 0;
        while (!b3.tx_ready && n < 50) begin tick(1); n++; end
        chk("tx3_ready_wait", 32'(b3.tx_ready), 32'd1);
        b3.tx_data  = w;
        b3.tx_valid = 1'b1;
        tick(1);
        b3.tx_valid = 1'b0;
        chk("tx3_ready_drop", 32'(b3.tx_ready), 32'd0);
    endtask

    // Mode 0 master: drive MOSI, raise SCK and capture MISO, then lower SCK
    task automatic xfer0(input logic [7:0] w, input int nbits, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            b0.mosi = w[7-i];
            tick(HALF);
            b0.sck = 1'b1;
            got = {got[6:0], b0.miso};
            tick(HALF);
            b0.sck = 1'b0;
        end
    endtask

    // Mode 3 LSB-first master: drive on falling SCK, capture on rising SCK
    task automatic xfer3(input logic [15:0] w, output logic [15:0] got);
        got = '0;
        for (int i = 0; i < 16; i++) begin
            b3.sck  = 1'b0;
            b3.mosi = w[i];
            tick(HALF);
            b3.sck  = 1'b1;
            got[i]  = b3.miso;
            tick(HALF);
        end
    endtask

    task automatic frame0(input logic [7:0] w, output logic [7:0] got);
        b0.ssel_n = 1'b0;
        tick(HALF);
        xfer0(w, 8, got);
        tick(HALF);
        b0.ssel_n = 1'b1;
        tick(HALF);
    endtask

    task automatic pulse_clr();
        b0.err_clr = 1'b1;
        tick(1);
        b0.err_clr = 1'b0;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  got, got2;
        logic [15:0] got16;

        vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[4] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};

        rst = 1'b1;
        b0.sck = 1'b0; b0.ssel_n = 1'b1; b0.mosi = 1'b0; b0.rx_ready = 1'b1;
        b0.tx_data = '0; b0.tx_valid = 1'b0; b0.err_clr = 1'b0;
        b3.sck = 1'b1; b3.ssel_n = 1'b1; b3.mosi = 1'b0; b3.rx_ready = 1'b1;
        b3.tx_data = '0; b3.tx_valid = 1'b0; b3.err_clr = 1'b0;
        tick(3);

        chk("rst_miso", 32'(b0.miso), 32'd0);
        chk("rst_miso_oe", 32'(b0.miso_oe), 32'd0);
        chk("rst_frame_active", 32'(b0.frame_active), 32'd0);
        chk("rst_rx_data", 32'(b0.rx_data), 32'd0);
        chk("rst_rx_valid", 32'(b0.rx_valid), 32'd0);
        chk("rst_tx_ready", 32'(b0.tx_ready), 32'd1);
        chk("rst_overrun", 32'(b0.overrun), 32'd0);
        chk("rst_underrun", 32'(b0.underrun), 32'd0);
        chk("rst3_tx_ready", 32'(b3.tx_ready), 32'd1);
        chk("rst3_rx_valid", 32'(b3.rx_valid), 32'd0);
        rst = 1'b0;
        tick(4);

        // Single-word mode 0 frames from the vector table
        for (int v = 0; v < 5; v++) begin
            load_tx0(vecs[v].tx);
            q0.push_back(vecs[v].exp_rx);
            b0.ssel_n = 1'b0;
            tick(HALF);
            chk("tbl_frame_active", 32'(b0.frame_active), 32'd1);
            chk("tbl_miso_oe", 32'(b0.miso_oe), 32'd1);
            chk("tbl_tx_ready_after_load", 32'(b0.tx_ready), 32'd1);
            xfer0(vecs[v].mosi, 8, got);
            tick(HALF);
            b0.ssel_n = 1'b1;
            tick(HALF);
            chk("tbl_miso_word", 32'(got), 32'(vecs[v].exp_miso));
            chk("tbl_frame_idle", 32'(b0.frame_active), 32'd0);
            chk("tbl_miso_idle", 32'(b0.miso), 32'd0);
            drain(0);
        end
        chk("tbl_underrun_tail", 32'(b0.underrun), FLAG_EXP);

        // Mode 3, 16-bit, LSB first
        load_tx3(16'hBEEF);
        q3.push_back(16'h1234);
        b3.ssel_n = 1'b0;
        tick(HALF);
        chk("m3_frame_active", 32'(b3.frame_active), 32'd1);
        chk("m3_first_bit", 32'(b3.miso), 32'd1);
        xfer3(16'h1234, got16);
        tick(HALF);
        b3.ssel_n = 1'b1;
        tick(HALF);
        chk("m3_miso_word", 32'(got16), 32'hBEEF);
        drain(3);
        chk("m3_rx_data", 32'(b3.rx_data), 32'h1234);

        // Two-word frame with the holding register refilled mid-frame
        load_tx0(8'h12);
        q0.push_back(8'h9C);
        q0.push_back(8'h3D);
        b0.ssel_n = 1'b0;
        tick(HALF);
        load_tx0(8'h34);
        xfer0(8'h9C, 8, got);
        xfer0(8'h3D, 8, got2);
        tick(HALF);
        b0.ssel_n = 1'b1;
        tick(HALF);
        chk("refill_word0", 32'(got), 32'h12);
        chk("refill_word1", 32'(got2), 32'h34);
        drain(0);

        // Two-word frame, holding register filled only for the first word
        pulse_clr();
        chk("und_cleared_pre", 32'(b0.underrun), 32'd0);
        load_tx0(8'h96);
        q0.push_back(8'h11);
        q0.push_back(8'h22);
        b0.ssel_n = 1'b0;
        tick(HALF);
        xfer0(8'h11, 8, got);
        xfer0(8'h22, 8, got2);
        tick(HALF);
        b0.ssel_n = 1'b1;
        tick(HALF);
        chk("und_word0", 32'(got), 32'h96);
        chk("und_word1_zero", 32'(got2), 32'h00);
        chk("und_flag", 32'(b0.underrun), FLAG_EXP);
        drain(0);
        pulse_clr();
        chk("und_err_clr", 32'(b0.underrun), 32'd0);

        // Overrun: two words with the consumer stalled
        b0.rx_ready = 1'b0;
        q0.push_back(8'hD2);
        b0.ssel_n = 1'b0;
        tick(HALF);
        xfer0(8'hC1, 8, got);
        xfer0(8'hD2, 8, got);
        tick(HALF);
        b0.ssel_n = 1'b1;
        tick(HALF);
        chk("ovr_rx_data", 32'(b0.rx_data), 32'hD2);
        chk("ovr_rx_valid", 32'(b0.rx_valid), 32'd1);
        chk("ovr_flag", 32'(b0.overrun), FLAG_EXP);
        b0.rx_ready = 1'b1;
        drain(0);
        tick(2);
        chk("ovr_rx_valid_acc", 32'(b0.rx_valid), 32'd0);
        pulse_clr();
        chk("ovr_err_clr", 32'(b0.overrun), 32'd0);

        // Abort after five bits; the word loaded mid-frame must survive the abort
        b0.ssel_n = 1'b0;
        tick(HALF);
        load_tx0(8'h69);
        xfer0(8'hFF, 5, got);
        tick(HALF);
        b0.ssel_n = 1'b1;
        tick(30);
        chk("abort_rx_valid", 32'(b0.rx_valid), 32'd0);
        chk("abort_hold_kept", 32'(b0.tx_ready), 32'd0);
        q0.push_back(8'h5A);
        frame0(8'h5A, got);
        chk("abort_next_miso", 32'(got), 32'h69);
        drain(0);
        chk("abort_next_rx_data", 32'(b0.rx_data), 32'h5A);

        // Asynchronous reset in the middle of a frame
        b0.rx_ready = 1'b0;
        frame0(8'h3E, got);
        tick(4);
        chk("rst_mid_pre_valid", 32'(b0.rx_valid), 32'd1);
        b0.ssel_n = 1'b0;
        tick(HALF);
        load_tx0(8'hE7);
        xfer0(8'hFF, 3, got);
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_miso", 32'(b0.miso), 32'd0);
        chk("rst_mid_miso_oe", 32'(b0.miso_oe), 32'd0);
        chk("rst_mid_frame", 32'(b0.frame_active), 32'd0);
        chk("rst_mid_rx_valid", 32'(b0.rx_valid), 32'd0);
        chk("rst_mid_rx_data", 32'(b0.rx_data), 32'd0);
        chk("rst_mid_tx_ready", 32'(b0.tx_ready), 32'd1);
        chk("rst_mid_underrun", 32'(b0.underrun), 32'd0);
        b0.ssel_n   = 1'b1;
        b0.sck      = 1'b0;
        b0.rx_ready = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(4);
        load_tx0(8'h88);
        q0.push_back(8'h77);
        frame0(8'h77, got);
        chk("post_rst_miso", 32'(got), 32'h88);
        drain(0);
        chk("post_rst_rx_data", 32'(b0.rx_data), 32'h77);

        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
Parameterised SPI slave, successor to the fixed 8-bit mode-0 slave.
- Supports configurable word width, all four CPOL/CPHA modes and MSB/LSB-first order.
- Uses valid/ready handshakes on both RX and TX, with a one-deep TX holding register.
- Sits between an external SPI master and the internal byte/word consumers, such as the character automaton. All SPI pins are oversampled in the system clock domain.

Parameters:
DATA_W, 8, bits per SPI word (4..32)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first; 0 = LSB first
SYNC_STAGES, 2, synchroniser depth before edge detect (2..3)

Ports:
clk  in  1  system clock; must be at least 4x SCK
rst  in  1  asynchronous, active-high reset
sck  in  1  SPI clock (async)
ssel_n  in  1  slave select, active low (async)
mosi  in  1  master-out data (async)
miso  out  1  slave-out data
miso_oe  out  1  high while the frame is active (external tri-state enable)
frame_active  out  1  synchronised, inverted ssel_n
rx_data  out  DATA_W  last received word
rx_valid  out  1  rx_data valid; held until it is accepted
rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
tx_data  in  DATA_W  next word to transmit
tx_valid  in  1  tx_data offered
tx_ready  out  1  holding register empty
overrun  out  1  sticky error flag (optional feature)
underrun  out  1  sticky error flag (optional feature)
err_clr  in  1  clears overrun/underrun

Behaviour:
- Reset state: all outputs 0, except tx_ready = 1. Shift registers, bit counter and holding register are cleared; holding register is marked empty.
- Synchronisation:
  - sck, ssel_n and mosi each pass through SYNC_STAGES flops, then one further flop for edge detection.
  - mosi is sampled from its synchronised copy.
- Edge selection:
  - Sample edge is rising when CPOL == CPHA, otherwise falling.
  - Shift edge is the opposite edge.
- Frame start (synchronised ssel_n falling):
  - Bit counter is set to 0.
  - TX shift register loads from the holding register if it is full, and the holding register is emptied. If the holding register is empty, the shift register loads all zeros and underrun is set.
- Sample edge while the frame is active:
  - Received bit enters the RX shift register at the LSB end (MSB_FIRST = 1) or the MSB end (MSB_FIRST = 0).
  - Bit counter increments and wraps from DATA_W-1 to 0.
- Word completion (sample edge with bit counter == DATA_W-1):
  - On the next clk, rx_data takes the full word and rx_valid goes to 1.
  - If rx_valid is already 1 and is not being accepted in that same cycle, the new word overwrites rx_data and overrun is set.
- miso output:
  - miso = MSB of the TX shift register (MSB_FIRST = 1) or LSB (MSB_FIRST = 0).
- miso in CPHA = 0: every shift edge shifts the TX register by one. The shift edge that follows word completion reloads the register instead, using the frame-start reload rule.
- miso in CPHA = 1:
  - The reload happens at word completion.
  - The first shift edge of each word does not shift, because the first bit is already presented.
  - Every other shift edge shifts the register.
- TX handshake:
  - The holding register accepts tx_data when tx_valid && tx_ready; tx_ready drops on the next clk.
  - If a reload and an accept occur in the same clk with the holding register empty, the reload sees empty (zeros loaded, underrun set) and the accepted word is stored for the next word.
  - If the holding register is full, a reload and tx_ready rising happen in the same clk.
- Abort: ssel_n rising mid-word discards the partial RX word (no rx_valid) and the TX shift contents, and clears the bit counter. The holding register, rx_data and rx_valid are retained.
- miso_oe = frame_active. miso is driven 0 when the frame is inactive.
- Latency: pin edge to internal action is SYNC_STAGES + 1 clk. The last sample edge reaches rx_valid 1 clk after that.

Optional Feature:
Macro: SPI_SLAVE_ERR_FLAGS_EN.
- Defined: overrun and underrun are sticky. Each clears on err_clr; if err_clr and a set event occur in the same clk, set wins.
- Undefined: overrun and underrun are tied to 0, err_clr is ignored, and no error logic is synthesised. Data behaviour is identical in both builds.

Test Plan:
1. Mode 0, DATA_W=8, master sends 0xA5 while tx_data = 0x3C is preloaded -> rx_data = 0xA5 and rx_valid = 1; MISO stream is 0,0,1,1,1,1,0,0.
2. Mode 3 (CPOL=1, CPHA=1), DATA_W=16, MSB_FIRST=0; master sends 0x1234 and slave sends 0xBEEF -> rx_data = 0x1234; master captures 0xBEEF; first SCK edge does not shift.
3. Two-word frame with the holding register refilled only for word 1 -> second word on MISO is 0x00 and underrun = 1; err_clr drops underrun to 0.
4. Two words received with rx_ready held low -> rx_data = second word, rx_valid = 1, overrun = 1; flags stay 0 when the macro is undefined.
5. ssel_n deasserted after 5 bits, then a new full frame with 0x5A -> no rx_valid for the aborted word; rx_data = 0x5A after the new frame.
6. rst asserted mid-frame, asynchronously -> all outputs 0 and tx_ready = 1 immediately; the next frame operates normally.
